// File: rtl/exec_pkg.sv
// Shared types for the execution unit: opcode encoding, special-register
// selector layout and the control FSM states.
package exec_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_MUL = 4'd8,
    OP_MFS = 4'd9,
    OP_MTS = 4'd10
  } op_e;

  typedef struct packed {
    logic [4:0] group;
    logic [2:0] regnum;
    logic [1:0] plevel;
  } sreg_sel_t;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/exec_mul.sv
// Iterative radix-2 shift-add multiplier, one partial product per cycle.
// The first partial product is taken on the start edge; done holds until ack.
module exec_mul #(
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ack,
  input  logic [REG_WIDTH-1:0] a,
  input  logic [REG_WIDTH-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [REG_WIDTH-1:0] product
);

  localparam int CW = $clog2(REG_WIDTH) + 1;

  logic                 busy_q;
  logic [CW-1:0]        cnt_q;
  logic [REG_WIDTH-1:0] a_q, b_q, acc_q;

  assign busy    = busy_q;
  assign done    = busy_q & (cnt_q == CW'(REG_WIDTH));
  assign product = acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(1);
    end else if (done && ack) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (busy_q && !done) begin
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  // Multiplicand shifts left, multiplier shifts right; bit 0 gates the add.
  always_ff @(posedge clk) begin
    if (start) begin
      acc_q <= b[0] ? a : '0;
      a_q   <= a << 1;
      b_q   <= b >> 1;
    end else if (busy_q && !done) begin
      acc_q <= acc_q + (b_q[0] ? a_q : '0);
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execution unit: single-cycle ALU / special-register moves plus an iterative
// multiplier, feeding one output register with valid/ready handshake.
module exec_unit
  import exec_pkg::*;
#(
  parameter int ADDR_WIDTH    = 30,
  parameter int REG_WIDTH     = 32,
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [ADDR_WIDTH-1:0]    in_addr,
  input  logic [RF_ADDR_WIDTH-1:0] in_rd,
  input  logic [REG_WIDTH-1:0]     in_a,
  input  logic [REG_WIDTH-1:0]     in_b,
  input  logic [9:0]               in_sreg_sel,
  input  logic                     sreg_rd_valid,
  input  logic [REG_WIDTH-1:0]     sreg_rd_val,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_WIDTH-1:0]    out_addr,
  output logic                     rf_wr_en,
  output logic [RF_ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [REG_WIDTH-1:0]     rf_wr_val,
  output logic                     sreg_wr_en,
  output logic [4:0]               sreg_wr_group,
  output logic [2:0]               sreg_wr_regnum,
  output logic [1:0]               sreg_wr_plevel,
  output logic [REG_WIDTH-1:0]     sreg_wr_val,
  output logic                     err
);

  localparam int SHW = $clog2(REG_WIDTH);

  state_e                   state_q, state_d;
  logic                     out_valid_q, rf_flag_q, sreg_flag_q;
  logic [ADDR_WIDTH-1:0]    out_addr_q, mul_addr_q;
  logic [RF_ADDR_WIDTH-1:0] rf_addr_q, mul_rd_q;
  logic [REG_WIDTH-1:0]     rf_val_q, sreg_val_q;
  sreg_sel_t                sel_q, sel_in;

  logic                     out_free, accept, is_mul, mul_ack;
  logic                     mul_busy, mul_done;
  logic [REG_WIDTH-1:0]     mul_prod;
  logic [REG_WIDTH-1:0]     res_d;
  logic                     rf_we_d, sreg_we_d, err_d;
  logic [SHW-1:0]           shamt;

  assign sel_in   = sreg_sel_t'(in_sreg_sel);
  assign shamt    = in_b[SHW-1:0];
  assign out_free = !out_valid_q | out_ready;
  assign in_ready = (state_q == IDLE) & out_free;
  assign accept   = in_valid & in_ready & !rst;
  assign is_mul   = accept & (in_op == OP_MUL);
  assign mul_ack  = (state_q == MUL_BUSY) & mul_busy & mul_done & out_free;

  exec_mul #(.REG_WIDTH(REG_WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (is_mul),
    .ack     (mul_ack),
    .a       (in_a),
    .b       (in_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (is_mul)  state_d = MUL_BUSY;
      MUL_BUSY: if (mul_ack) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    res_d     = '0;
    rf_we_d   = 1'b0;
    sreg_we_d = 1'b0;
    err_d     = 1'b0;
    case (in_op)
      OP_NOP: ;
      OP_ADD: begin res_d = in_a + in_b;      rf_we_d = 1'b1; end
      OP_SUB: begin res_d = in_a - in_b;      rf_we_d = 1'b1; end
      OP_AND: begin res_d = in_a & in_b;      rf_we_d = 1'b1; end
      OP_OR:  begin res_d = in_a | in_b;      rf_we_d = 1'b1; end
      OP_XOR: begin res_d = in_a ^ in_b;      rf_we_d = 1'b1; end
      OP_SLL: begin res_d = in_a << shamt;    rf_we_d = 1'b1; end
      OP_SRL: begin res_d = in_a >> shamt;    rf_we_d = 1'b1; end
      OP_MUL: ;
      OP_MFS: begin
        res_d   = sreg_rd_val;
        rf_we_d = sreg_rd_valid;
        err_d   = !sreg_rd_valid;
      end
      OP_MTS: sreg_we_d = 1'b1;
      default: err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((accept && !is_mul) || mul_ack) out_valid_q <= 1'b1;
      else if (out_ready)                 out_valid_q <= 1'b0;
    end
  end

  // Output register loads only when free, so it holds stable while stalled.
  always_ff @(posedge clk) begin
    if (accept && !is_mul) begin
      out_addr_q  <= in_addr;
      rf_addr_q   <= in_rd;
      rf_val_q    <= res_d;
      rf_flag_q   <= rf_we_d;
      sreg_flag_q <= sreg_we_d;
      sel_q       <= sel_in;
      sreg_val_q  <= in_a;
    end else if (mul_ack) begin
      out_addr_q  <= mul_addr_q;
      rf_addr_q   <= mul_rd_q;
      rf_val_q    <= mul_prod;
      rf_flag_q   <= 1'b1;
      sreg_flag_q <= 1'b0;
    end
    if (is_mul) begin
      mul_addr_q <= in_addr;
      mul_rd_q   <= in_rd;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_addr       = out_addr_q;
  assign rf_wr_en       = out_valid_q & out_ready & rf_flag_q & !rst;
  assign rf_wr_addr     = rf_addr_q;
  assign rf_wr_val      = rf_val_q;
  assign sreg_wr_en     = out_valid_q & out_ready & sreg_flag_q & !rst;
  assign sreg_wr_group  = sel_q.group;
  assign sreg_wr_regnum = sel_q.regnum;
  assign sreg_wr_plevel = sel_q.plevel;
  assign sreg_wr_val    = sreg_val_q;
  assign err            = accept & err_d;

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 30, word address of the instruction.
REQ-002 SHALL have parameter REG_WIDTH, default 32, datapath width; power of two, 8..64.
REQ-003 SHALL have parameter RF_ADDR_WIDTH, default 5, register file index width.
REQ-004 SHALL have ports clk in 1, system clock; rst in 1, reset, synchronous, active-high.
REQ-005 SHALL have in_valid in 1, upstream op valid; in_ready out 1, unit can accept.
REQ-006 SHALL have in_op in 4, opcode (exec_pkg::op_e); in_addr in ADDR_WIDTH, instruction address.
REQ-007 SHALL have in_rd in RF_ADDR_WIDTH, destination register; in_a in REG_WIDTH, operand A; in_b in REG_WIDTH, operand B.
REQ-008 SHALL have in_sreg_sel in 10, {group[4:0], regnum[2:0], plevel[1:0]} for MTS.
REQ-009 SHALL have sreg_rd_valid in 1 and sreg_rd_val in REG_WIDTH, special-register read result for MFS.
REQ-010 SHALL have out_valid out 1, result held; out_ready in 1, downstream accepts; out_addr out ADDR_WIDTH.
REQ-011 SHALL have rf_wr_en out 1, rf_wr_addr out RF_ADDR_WIDTH, rf_wr_val out REG_WIDTH, register file write.
REQ-012 SHALL have sreg_wr_en out 1, sreg_wr_group out 5, sreg_wr_regnum out 3, sreg_wr_plevel out 2, sreg_wr_val out REG_WIDTH.
REQ-013 SHALL have err out 1, pulses for one cycle on illegal opcode or invalid MFS read.

Function
REQ-014 Opcodes SHALL be NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, SLL=6, SRL=7, MUL=8, MFS=9, MTS=10; 11..15 illegal.
REQ-015 Accept SHALL occur when in_valid & in_ready; in_ready = (state==IDLE) & (!out_valid | out_ready).
REQ-016 Single-cycle ops (0..7, 9, 10) SHALL set out_valid the cycle after accept: latency 1.
REQ-017 ADD/SUB/logic SHALL produce results modulo 2^REG_WIDTH; SLL/SRL SHALL shift in_a by in_b[$clog2(REG_WIDTH)-1:0], logical.
REQ-018 MUL SHALL be a radix-2 shift-add iteration, one bit per cycle, producing the low REG_WIDTH bits of in_a*in_b, unsigned.
REQ-019 MUL SHALL set out_valid REG_WIDTH+1 cycles after accept; in_ready SHALL be 0 throughout.
REQ-020 The FSM SHALL have states IDLE and MUL_BUSY: IDLE->MUL_BUSY on MUL accept; MUL_BUSY->IDLE when the iteration count reaches REG_WIDTH and the output register is free (!out_valid | out_ready).
REQ-021 In MUL_BUSY with a blocked output, the FSM SHALL hold the final product until the output register frees.
REQ-022 MFS SHALL sample sreg_rd_val at accept and write it to in_rd; if sreg_rd_valid=0, the RF write SHALL be suppressed and err SHALL pulse at accept.
REQ-023 MTS SHALL produce sreg_wr_val=in_a and group/regnum/plevel from in_sreg_sel, with no RF write.
REQ-024 ALU ops and MUL SHALL write the result to in_rd.
REQ-025 NOP and illegal ops SHALL produce out_valid with no writes; illegal ops SHALL also pulse err at accept.
REQ-026 rf_wr_en and sreg_wr_en SHALL equal out_valid & out_ready & the corresponding write flag, so each committed op writes exactly once.
REQ-027 While out_valid & !out_ready, all out_*/rf_wr_addr/rf_wr_val/sreg_wr_* SHALL hold stable.
REQ-028 A new op SHALL be accepted in the same cycle the previous result transfers (full throughput for single-cycle ops).

Reset
REQ-029 rst SHALL force state=IDLE and out_valid=0, and clear the iteration counter, rf_wr_en, sreg_wr_en and err to 0; data registers need no reset.
REQ-030 rst mid-MUL SHALL abort the operation with no result and no write; in_ready=1 the cycle after rst deasserts.

Structure
REQ-031 The op_e enum, opcode values and the sreg_sel_t struct {group, regnum, plevel} SHALL live in exec_pkg.
REQ-032 The iterative multiplier SHALL be the sub-module exec_mul (start, a, b, busy, done, product), parameterised by REG_WIDTH.

Verification
REQ-033 ADD a=0xFFFFFFFF, b=1, rd=3 -> next cycle out_valid, and on out_ready rf_wr_en=1, addr=3, val=0.
REQ-034 MUL a=7, b=6 -> in_ready=0 for 32 cycles, out_valid at cycle 33, rf_wr_val=42.
REQ-035 MTS a=0x55, sel={10,7,0} with out_ready=0 for 3 cycles -> outputs stable, a single sreg_wr_en pulse (group 10, regnum 7, val 0x55).
REQ-036 MFS with sreg_rd_valid=0 -> err pulse, out_valid, rf_wr_en never asserted; opcode 0xF -> err pulse and no writes.
REQ-037 Back-to-back ADDs with out_ready=1 -> one result per cycle; rst asserted at MUL cycle 10 -> no write and in_ready=1 after release.
